// File: rtl/ping_pong_checker.sv
// Scoreboard for the 4-bit ping-pong counter: predicts each out/direction
// transition from the previous sample, flags mismatches and keeps statistics.
module ping_pong_checker #(
  parameter int CNT_W       = 8,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dut_rst_n,
  input  logic             enable,
  input  logic             flip,
  input  logic [3:0]       max,
  input  logic [3:0]       min,
  input  logic [3:0]       obs_out,
  input  logic             obs_dir,
  output logic             locked,
  output logic             mismatch,
  output logic             fail,
  output logic [3:0]       exp_out,
  output logic             exp_dir,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bounce_cnt
);

  typedef enum logic [1:0] {IDLE, CHECK, HALT} state_t;

  state_t     state, state_nxt;
  logic       capture, compare, miss;
  logic       valid, turn;
  logic [3:0] pred_out;
  logic       pred_dir;

  logic [3:0] out_p0, max_p0, min_p0;
  logic       dir_p0, en_p0, flip_p0, rstn_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // stage p0: counter state before its update, plus the stimulus it saw
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_p0  <= 4'd0;
      dir_p0  <= 1'b1;
      en_p0   <= 1'b0;
      flip_p0 <= 1'b0;
      max_p0  <= 4'd0;
      min_p0  <= 4'd0;
      rstn_p0 <= 1'b1;
    end else if (capture) begin
      out_p0  <= obs_out;
      dir_p0  <= obs_dir;
      en_p0   <= enable;
      flip_p0 <= flip;
      max_p0  <= max;
      min_p0  <= min;
      rstn_p0 <= dut_rst_n;
    end
  end

  // prediction of the counter's next registered state from the p0 sample
  always_comb begin
    valid = en_p0 && (min_p0 < max_p0) && (out_p0 >= min_p0) && (out_p0 <= max_p0);
    turn  = (dir_p0 && (out_p0 == max_p0)) || (!dir_p0 && (out_p0 == min_p0)) ||
            ((out_p0 > min_p0) && (out_p0 < max_p0) && flip_p0);
    pred_out = out_p0;
    pred_dir = dir_p0;
    if (!rstn_p0) begin
      pred_out = min_p0;
      pred_dir = 1'b1;
    end else if (valid) begin
      pred_dir = dir_p0 ^ turn;
      // the step direction is the one held before this edge
      if (dir_p0) pred_out = (out_p0 != max_p0) ? out_p0 + 4'd1 : out_p0 - 4'd1;
      else        pred_out = (out_p0 != min_p0) ? out_p0 - 4'd1 : out_p0 + 4'd1;
    end
  end

  assign miss = (obs_out != pred_out) || (obs_dir != pred_dir);

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    compare   = 1'b0;
    case (state)
      IDLE: begin
        capture   = 1'b1;
        state_nxt = CHECK;
      end
      CHECK: begin
        capture = 1'b1;
        compare = 1'b1;
        if (miss && STOP_ON_ERR) state_nxt = HALT;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign locked = (state == CHECK);

  // stage p1: compare results and statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch   <= 1'b0;
      fail       <= 1'b0;
      exp_out    <= 4'd0;
      exp_dir    <= 1'b0;
      err_cnt    <= '0;
      bounce_cnt <= '0;
    end else begin
      mismatch <= compare && miss;
      if (compare) begin
        exp_out <= pred_out;
        exp_dir <= pred_dir;
        if (miss) begin
          fail    <= 1'b1;
          err_cnt <= sat_inc(err_cnt);
        end else if (obs_dir != dir_p0) begin
          bounce_cnt <= bounce_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ping_pong_checker.sv
// Directed bench for ping_pong_checker: three instances (free-running, stop-on-error,
// 2-bit counters) share one stimulus stream and are checked against a behavioural model.
module tb_ping_pong_checker;

  typedef struct packed {
    logic [3:0] out;
    logic       dir;
    logic       en;
    logic       flip;
    logic [3:0] max;
    logic [3:0] min;
    logic       rstn;
  } smp_t;

  localparam smp_t SMP_RST = {4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1};

  logic       clk = 1'b0;
  logic       rst;
  logic       s_rstn, s_en, s_flip, s_dir;
  logic [3:0] s_max, s_min, s_obs;

  logic [2:0] locked_v, mismatch_v, fail_v, exp_dir_v;
  logic [3:0] eo0, eo1, eo2;
  logic [7:0] err0, err1, bnc0, bnc1;
  logic [1:0] err2, bnc2;

  logic [7:0] a_err [3];
  logic [7:0] a_bnc [3];
  logic [3:0] a_eo  [3];

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0] cnt_out;
  logic       cnt_dir;

  always #5 clk = ~clk;

  ping_pong_checker #(.CNT_W(8), .STOP_ON_ERR(1'b0)) u0 (
    .clk(clk), .rst(rst), .dut_rst_n(s_rstn), .enable(s_en), .flip(s_flip),
    .max(s_max), .min(s_min), .obs_out(s_obs), .obs_dir(s_dir),
    .locked(locked_v[0]), .mismatch(mismatch_v[0]), .fail(fail_v[0]),
    .exp_out(eo0), .exp_dir(exp_dir_v[0]), .err_cnt(err0), .bounce_cnt(bnc0));

  ping_pong_checker #(.CNT_W(8), .STOP_ON_ERR(1'b1)) u1 (
    .clk(clk), .rst(rst), .dut_rst_n(s_rstn), .enable(s_en), .flip(s_flip),
    .max(s_max), .min(s_min), .obs_out(s_obs), .obs_dir(s_dir),
    .locked(locked_v[1]), .mismatch(mismatch_v[1]), .fail(fail_v[1]),
    .exp_out(eo1), .exp_dir(exp_dir_v[1]), .err_cnt(err1), .bounce_cnt(bnc1));

  ping_pong_checker #(.CNT_W(2), .STOP_ON_ERR(1'b0)) u2 (
    .clk(clk), .rst(rst), .dut_rst_n(s_rstn), .enable(s_en), .flip(s_flip),
    .max(s_max), .min(s_min), .obs_out(s_obs), .obs_dir(s_dir),
    .locked(locked_v[2]), .mismatch(mismatch_v[2]), .fail(fail_v[2]),
    .exp_out(eo2), .exp_dir(exp_dir_v[2]), .err_cnt(err2), .bounce_cnt(bnc2));

  always_comb begin
    a_err[0] = err0;  a_err[1] = err1;  a_err[2] = {6'd0, err2};
    a_bnc[0] = bnc0;  a_bnc[1] = bnc1;  a_bnc[2] = {6'd0, bnc2};
    a_eo[0]  = eo0;   a_eo[1]  = eo1;   a_eo[2]  = eo2;
  end

  // What the ping-pong counter does in one clock, given its state and inputs.
  function automatic logic [4:0] counter_next(input smp_t s);
    int   o, lo, hi, nxt;
    logic up, rev;
    o  = int'(s.out);
    lo = int'(s.min);
    hi = int'(s.max);
    up = s.dir;
    if (!s.rstn) return {s.min, 1'b1};
    if (!s.en || lo >= hi || o < lo || o > hi) return {s.out, s.dir};
    if (up) nxt = (o == hi) ? o - 1 : o + 1;
    else    nxt = (o == lo) ? o + 1 : o - 1;
    rev = up ? (o == hi) : (o == lo);
    if (o > lo && o < hi && s.flip) rev = 1'b1;
    nxt = nxt & 15;
    return {nxt[3:0], up ^ rev};
  endfunction

  function automatic int cap_of(input int i);
    return (i == 2) ? 3 : 255;
  endfunction

  // ---------------- behavioural model of the three checkers ----------------
  smp_t       cur;
  smp_t       m_smp  [3];
  logic [4:0] m_pred [3];
  int         m_st   [3];   // 0 waiting for first sample, 1 checking, 2 halted
  logic       m_mis  [3];
  logic       m_fail [3];
  logic [3:0] m_eo   [3];
  logic       m_ed   [3];
  int         m_err  [3];
  int         m_bnc  [3];

  assign cur = {s_obs, s_dir, s_en, s_flip, s_max, s_min, s_rstn};

  always_comb begin
    for (int i = 0; i < 3; i++) m_pred[i] = counter_next(m_smp[i]);
  end

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_st[i] <= 0;  m_mis[i] <= 1'b0; m_fail[i] <= 1'b0;
        m_eo[i] <= 4'd0; m_ed[i] <= 1'b0; m_err[i] <= 0; m_bnc[i] <= 0;
        m_smp[i] <= SMP_RST;
      end else if (m_st[i] == 2) begin
        m_mis[i] <= 1'b0;
      end else begin
        m_smp[i] <= cur;
        m_mis[i] <= 1'b0;
        if (m_st[i] == 0) begin
          m_st[i] <= 1;
        end else begin
          m_eo[i] <= m_pred[i][4:1];
          m_ed[i] <= m_pred[i][0];
          if ({s_obs, s_dir} != m_pred[i]) begin
            m_mis[i]  <= 1'b1;
            m_fail[i] <= 1'b1;
            m_err[i]  <= (m_err[i] < cap_of(i)) ? m_err[i] + 1 : m_err[i];
            if (i == 1) m_st[i] <= 2;
          end else if (s_dir != m_smp[i].dir) begin
            m_bnc[i] <= (m_bnc[i] + 1) & cap_of(i);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d.locked", i),   32'(locked_v[i]),   32'(m_st[i] == 1));
      chk($sformatf("u%0d.mismatch", i), 32'(mismatch_v[i]), 32'(m_mis[i]));
      chk($sformatf("u%0d.fail", i),     32'(fail_v[i]),     32'(m_fail[i]));
      chk($sformatf("u%0d.exp_out", i),  32'(a_eo[i]),       32'(m_eo[i]));
      chk($sformatf("u%0d.exp_dir", i),  32'(exp_dir_v[i]),  32'(m_ed[i]));
      chk($sformatf("u%0d.err_cnt", i),  32'(a_err[i]),      32'(m_err[i]));
      chk($sformatf("u%0d.bounce", i),   32'(a_bnc[i]),      32'(m_bnc[i]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic apply(input logic rn, input logic en, input logic fl,
                       input logic [3:0] mx, input logic [3:0] mn,
                       input logic [3:0] o, input logic d);
    s_rstn = rn; s_en = en; s_flip = fl; s_max = mx; s_min = mn; s_obs = o; s_dir = d;
    @(posedge clk);
    #1;
  endtask

  task automatic run_cnt(input logic rn, input logic en, input logic fl,
                         input logic [3:0] mx, input logic [3:0] mn);
    smp_t s;
    s = {cnt_out, cnt_dir, en, fl, mx, mn, rn};
    apply(rn, en, fl, mx, mn, cnt_out, cnt_dir);
    {cnt_out, cnt_dir} = counter_next(s);
  endtask

  task automatic force_obs(input logic rn, input logic en, input logic fl,
                           input logic [3:0] mx, input logic [3:0] mn,
                           input logic [3:0] o, input logic d);
    smp_t s;
    s = {cnt_out, cnt_dir, en, fl, mx, mn, rn};
    apply(rn, en, fl, mx, mn, o, d);
    {cnt_out, cnt_dir} = counter_next(s);
  endtask

  task automatic do_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    s_rstn = 1'b1; s_en = 1'b0; s_flip = 1'b0; s_max = 4'd0; s_min = 4'd0;
    s_obs = 4'd0; s_dir = 1'b0;
    cnt_out = 4'd0; cnt_dir = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.locked", 32'(locked_v), 32'd0);
    chk("reset.fail",   32'(fail_v),   32'd0);
    chk("reset.err0",   32'(err0),     32'd0);
    rst = 1'b0;

    // normal bounce between 2 and 5
    run_cnt(1'b0, 1'b1, 1'b0, 4'd5, 4'd2);
    chk("bounce.locked_after_first", 32'(locked_v[0]), 32'd1);
    repeat (8) run_cnt(1'b1, 1'b1, 1'b0, 4'd5, 4'd2);
    chk("bounce.count",    32'(bnc0),          32'd2);
    chk("bounce.no_err",   32'(err0),          32'd0);
    chk("bounce.exp_out",  32'(eo0),           32'd3);
    chk("bounce.fail",     32'(fail_v[0]),     32'd0);

    // flip mid-range, then a corrupted observation
    do_rst();
    cnt_out = 4'd7; cnt_dir = 1'b1;
    run_cnt(1'b1, 1'b0, 1'b0, 4'd15, 4'd0);
    run_cnt(1'b1, 1'b1, 1'b1, 4'd15, 4'd0);
    force_obs(1'b1, 1'b1, 1'b0, 4'd15, 4'd0, 4'd8, 1'b1);
    chk("flip.mismatch", 32'(mismatch_v[0]), 32'd1);
    chk("flip.err",      32'(err0),          32'd1);
    chk("flip.fail",     32'(fail_v[0]),     32'd1);
    chk("flip.exp_out",  32'(eo0),           32'd8);
    chk("flip.exp_dir",  32'(exp_dir_v[0]),  32'd0);
    chk("flip.u1_halt",  32'(locked_v[1]),   32'd0);
    run_cnt(1'b1, 1'b1, 1'b0, 4'd15, 4'd0);
    run_cnt(1'b1, 1'b1, 1'b0, 4'd15, 4'd0);
    chk("flip.resync_mis", 32'(mismatch_v[0]), 32'd0);
    chk("flip.resync_err", 32'(err0),          32'd2);

    // invalid range holds
    do_rst();
    cnt_out = 4'd9; cnt_dir = 1'b1;
    run_cnt(1'b1, 1'b1, 1'b0, 4'd3, 4'd9);
    run_cnt(1'b1, 1'b1, 1'b0, 4'd3, 4'd9);
    force_obs(1'b1, 1'b1, 1'b0, 4'd3, 4'd9, 4'd10, 1'b1);
    chk("invalid.exp_out",  32'(eo0),           32'd9);
    chk("invalid.mismatch", 32'(mismatch_v[0]), 32'd1);

    // out of range, counter reset with enable+flip, disabled hold
    do_rst();
    cnt_out = 4'd12; cnt_dir = 1'b0;
    repeat (3) run_cnt(1'b1, 1'b1, 1'b0, 4'd8, 4'd4);
    chk("oor.exp_out", 32'(eo0),          32'd12);
    chk("oor.exp_dir", 32'(exp_dir_v[0]), 32'd0);
    run_cnt(1'b0, 1'b1, 1'b1, 4'd8, 4'd4);
    run_cnt(1'b1, 1'b0, 1'b0, 4'd8, 4'd4);
    chk("rstwin.exp_out", 32'(eo0),          32'd4);
    chk("rstwin.exp_dir", 32'(exp_dir_v[0]), 32'd1);
    repeat (2) run_cnt(1'b1, 1'b0, 1'b0, 4'd8, 4'd4);
    chk("disable.err", 32'(err0), 32'd0);

    // stop-on-error freeze
    do_rst();
    cnt_out = 4'd0; cnt_dir = 1'b1;
    run_cnt(1'b0, 1'b1, 1'b0, 4'd6, 4'd1);
    repeat (3) run_cnt(1'b1, 1'b1, 1'b0, 4'd6, 4'd1);
    force_obs(1'b1, 1'b1, 1'b0, 4'd6, 4'd1, 4'd9, 1'b1);
    chk("halt.err",  32'(err1),      32'd1);
    chk("halt.fail", 32'(fail_v[1]), 32'd1);
    repeat (10) run_cnt(1'b1, 1'b1, 1'b0, 4'd6, 4'd1);
    chk("halt.frozen_err", 32'(err1),          32'd1);
    chk("halt.mismatch",   32'(mismatch_v[1]), 32'd0);
    chk("halt.locked",     32'(locked_v[1]),   32'd0);
    chk("halt.exp_out",    32'(eo1),           32'd4);
    do_rst();
    chk("halt.rst_err",  32'(err1),      32'd0);
    chk("halt.rst_fail", 32'(fail_v[1]), 32'd0);

    // saturation of the 2-bit error counter
    cnt_out = 4'd9; cnt_dir = 1'b1;
    run_cnt(1'b1, 1'b1, 1'b0, 4'd3, 4'd9);
    force_obs(1'b1, 1'b1, 1'b0, 4'd3, 4'd9, 4'd10, 1'b1);
    force_obs(1'b1, 1'b1, 1'b0, 4'd3, 4'd9, 4'd9,  1'b1);
    force_obs(1'b1, 1'b1, 1'b0, 4'd3, 4'd9, 4'd10, 1'b1);
    force_obs(1'b1, 1'b1, 1'b0, 4'd3, 4'd9, 4'd9,  1'b1);
    force_obs(1'b1, 1'b1, 1'b0, 4'd3, 4'd9, 4'd10, 1'b1);
    chk("sat.err2", 32'(err2), 32'd3);
    chk("sat.err0", 32'(err0), 32'd5);

    // asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    chk("arst.locked",   32'(locked_v),   32'd0);
    chk("arst.mismatch", 32'(mismatch_v), 32'd0);
    chk("arst.fail",     32'(fail_v),     32'd0);
    chk("arst.err0",     32'(err0),       32'd0);
    chk("arst.err2",     32'(err2),       32'd0);
    chk("arst.exp_out",  32'(eo0),        32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) run_cnt(1'b1, 1'b0, 1'b0, 4'd3, 4'd9);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
